hud_game_controller: RTL and testbench

Sequential game-state engine for the card-match HUD. It runs the per-turn 15-second countdown, keeps each player's pair count, decides whose turn it is, and declares the winner. Every display field is a registered 4-bit code that goes straight to the `SevenSegDecoder` instances of the HUD. It sits directly upstream of the HUD: board/matching logic drives it with match/miss pulses, and its outputs replace the HUD's hard-wired constants.

---
 rtl/hud_game_controller.sv | 162 ++++++++++++++++
 tb/tb_hud_game_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hud_game_controller.sv
// hud_game_controller
//   Game-state engine for the card-match HUD: per-turn BCD countdown,
//   per-player pair counts, turn ownership and winner declaration.
//   Every display field is registered and feeds a SevenSegDecoder directly.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per countdown second
//   TURN_SECS      turn length in seconds (1..99), loaded as BCD
//   PAIRS          total pairs on the board (1..18)
//
// Ports
//   CLOCK_50    in   system clock
//   reset       in   asynchronous, active-high
//   start       in   level; begins a new game from IDLE or OVER
//   match       in   1-cycle pulse; current player found a pair
//   miss        in   1-cycle pulse; current player flipped a non-pair
//   timer_tens  out  BCD tens digit of seconds remaining
//   timer_ones  out  BCD ones digit of seconds remaining
//   p1_score    out  player 1 pairs (0..9)
//   p2_score    out  player 2 pairs (0..9)
//   cur_player  out  player to move (1 or 2)
//   winner      out  0 = undecided/tie, else winning player
//   game_over   out  high while in OVER
//   sec_tick    out  1-cycle strobe at each countdown second
module hud_game_controller #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 15,
  parameter int PAIRS         = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       match,
  input  logic       miss,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] cur_player,
  output logic [3:0] winner,
  output logic       game_over,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    RELOAD_TENS = 4'(TURN_SECS / 10);
  localparam logic [3:0]    RELOAD_ONES = 4'(TURN_SECS % 10);
  localparam logic [4:0]    PAIRS_W     = 5'(PAIRS);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    tens_n, ones_n, p1_n, p2_n, cur_n, win_n;
  logic          over_n, tick_n;
  logic          wrap, timeout;
  logic [3:0]    p1_inc, p2_inc, cur_other;
  logic [4:0]    pair_sum;

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    tens_n    = timer_tens;
    ones_n    = timer_ones;
    p1_n      = p1_score;
    p2_n      = p2_score;
    cur_n     = cur_player;
    win_n     = winner;
    over_n    = game_over;
    tick_n    = 1'b0;
    pair_sum  = '0;
    wrap      = (presc == PRESC_LAST);
    timeout   = (timer_tens == 4'd0) && (timer_ones == 4'd1);
    p1_inc    = (p1_score == 4'd9) ? 4'd9 : p1_score + 4'd1;
    p2_inc    = (p2_score == 4'd9) ? 4'd9 : p2_score + 4'd1;
    cur_other = (cur_player == 4'h1) ? 4'h2 : 4'h1;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n = PLAY;
          presc_n = '0;
          tens_n  = RELOAD_TENS;
          ones_n  = RELOAD_ONES;
          p1_n    = '0;
          p2_n    = '0;
          cur_n   = 4'h1;
          win_n   = '0;
          over_n  = 1'b0;
        end
      end
      PLAY: begin
        // match/miss take precedence over the prescaler wrap, so a
        // coincident wrap is swallowed and the next second starts afresh.
        if (match) begin
          if (cur_player == 4'h1) p1_n = p1_inc;
          else                    p2_n = p2_inc;
          presc_n  = '0;
          tens_n   = RELOAD_TENS;
          ones_n   = RELOAD_ONES;
          pair_sum = {1'b0, p1_n} + {1'b0, p2_n};
          if (pair_sum == PAIRS_W) begin
            state_n = OVER;
            over_n  = 1'b1;
            if (p1_n > p2_n)      win_n = 4'h1;
            else if (p2_n > p1_n) win_n = 4'h2;
            else                  win_n = 4'h0;
          end
        end else if (miss) begin
          cur_n   = cur_other;
          presc_n = '0;
          tens_n  = RELOAD_TENS;
          ones_n  = RELOAD_ONES;
        end else if (wrap) begin
          presc_n = '0;
          tick_n  = 1'b1;
          if (timeout) begin
            cur_n  = cur_other;
            tens_n = RELOAD_TENS;
            ones_n = RELOAD_ONES;
          end else if (timer_ones == 4'd0) begin
            ones_n = 4'd9;
            tens_n = timer_tens - 4'd1;
          end else begin
            ones_n = timer_ones - 4'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      timer_tens <= RELOAD_TENS;
      timer_ones <= RELOAD_ONES;
      p1_score   <= '0;
      p2_score   <= '0;
      cur_player <= 4'h1;
      winner     <= '0;
      game_over  <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      timer_tens <= tens_n;
      timer_ones <= ones_n;
      p1_score   <= p1_n;
      p2_score   <= p2_n;
      cur_player <= cur_n;
      winner     <= win_n;
      game_over  <= over_n;
      sec_tick   <= tick_n;
    end
  end

endmodule

// File: tb/tb_hud_game_controller.sv
// tb_hud_game_controller
//   Directed bench for hud_game_controller with TICKS_PER_SEC=4,
//   TURN_SECS=15, PAIRS=8. Inputs change 1 time unit after a rising edge,
//   outputs are sampled at the same point.
module tb_hud_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       match = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] timer_tens, timer_ones, p1_score, p2_score, cur_player, winner;
  logic       game_over, sec_tick;

  int checks = 0;
  int failures = 0;

  hud_game_controller #(
    .TICKS_PER_SEC(4),
    .TURN_SECS(15),
    .PAIRS(8)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .start(start),
    .match(match),
    .miss(miss),
    .timer_tens(timer_tens),
    .timer_ones(timer_ones),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .cur_player(cur_player),
    .winner(winner),
    .game_over(game_over),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic m, input logic x);
    match = m;
    miss  = x;
    tick(1);
    match = 1'b0;
    miss  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_timer(input string tag, input logic [3:0] t, input logic [3:0] o);
    check({tag, "_tens"}, 32'(timer_tens), 32'(t));
    check({tag, "_ones"}, 32'(timer_ones), 32'(o));
  endtask

  task automatic check_reset_vals(input string tag);
    check_timer(tag, 4'd1, 4'd5);
    check({tag, "_p1"}, 32'(p1_score), 0);
    check({tag, "_p2"}, 32'(p2_score), 0);
    check({tag, "_cur"}, 32'(cur_player), 1);
    check({tag, "_win"}, 32'(winner), 0);
    check({tag, "_over"}, 32'(game_over), 0);
    check({tag, "_tick"}, 32'(sec_tick), 0);
  endtask

  initial begin
    // 1. asynchronous reset between edges, no clock edge needed
    #2 reset = 1'b1;
    #1 check_reset_vals("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(6);
    check_timer("idle_hold", 4'd1, 4'd5);
    check("idle_tick", 32'(sec_tick), 0);

    // 2. countdown and timeout
    do_start();
    check("start_cur", 32'(cur_player), 1);
    tick(3);
    check("pre_tick", 32'(sec_tick), 0);
    check_timer("pre_tick", 4'd1, 4'd5);
    tick(1);
    check("tick1", 32'(sec_tick), 1);
    check_timer("t4", 4'd1, 4'd4);
    tick(1);
    check("tick1_end", 32'(sec_tick), 0);
    tick(35);
    check_timer("t40", 4'd0, 4'd5);
    check("tick10", 32'(sec_tick), 1);
    tick(19);
    check_timer("t59", 4'd0, 4'd1);
    check("t59_cur", 32'(cur_player), 1);
    tick(1);
    check("timeout_cur", 32'(cur_player), 2);
    check_timer("timeout", 4'd1, 4'd5);
    check("timeout_tick", 32'(sec_tick), 1);

    // 4. match+miss coinciding with a wrap, P2 to move
    tick(3);
    match = 1'b1;
    miss  = 1'b1;
    tick(1);
    match = 1'b0;
    miss  = 1'b0;
    check("sim_p2", 32'(p2_score), 1);
    check("sim_cur", 32'(cur_player), 2);
    check_timer("sim", 4'd1, 4'd5);
    check("sim_tick", 32'(sec_tick), 0);
    tick(3);
    check("sim_next_early", 32'(sec_tick), 0);
    tick(1);
    check("sim_next_tick", 32'(sec_tick), 1);
    check_timer("sim_next", 4'd1, 4'd4);

    // plain miss hands turn back to P1
    pulse(1'b0, 1'b1);
    check("miss_cur1", 32'(cur_player), 1);
    check_timer("miss1", 4'd1, 4'd5);

    // 3. scoring: each match reloads the timer from 14
    for (int k = 1; k <= 3; k++) begin
      tick(4);
      check_timer("pre_match", 4'd1, 4'd4);
      pulse(1'b1, 1'b0);
      check("match_p1", 32'(p1_score), 32'(k));
      check("match_cur", 32'(cur_player), 1);
      check_timer("match", 4'd1, 4'd5);
    end
    pulse(1'b0, 1'b1);
    check("miss_cur2", 32'(cur_player), 2);
    check("miss_p2", 32'(p2_score), 1);
    check("miss_p1", 32'(p1_score), 3);

    // start in PLAY is ignored
    do_start();
    check("play_start_p1", 32'(p1_score), 3);
    check("play_start_cur", 32'(cur_player), 2);

    // 5. game end at P1=5, P2=3
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("p2_3", 32'(p2_score), 3);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    check("pre_end_over", 32'(game_over), 0);
    check("pre_end_win", 32'(winner), 0);
    pulse(1'b1, 1'b0);
    check("end_p1", 32'(p1_score), 5);
    check("end_over", 32'(game_over), 1);
    check("end_win", 32'(winner), 1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    tick(8);
    check("over_p1", 32'(p1_score), 5);
    check("over_p2", 32'(p2_score), 3);
    check("over_cur", 32'(cur_player), 1);
    check("over_tick", 32'(sec_tick), 0);
    check_timer("over", 4'd1, 4'd5);
    check("over_hold", 32'(game_over), 1);

    // restart from OVER, then a 4/4 tie
    do_start();
    check_reset_vals("restart");
    for (int k = 0; k < 4; k++) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) pulse(1'b1, 1'b0);
    check("tie_pre_over", 32'(game_over), 0);
    pulse(1'b1, 1'b0);
    check("tie_p1", 32'(p1_score), 4);
    check("tie_p2", 32'(p2_score), 4);
    check("tie_over", 32'(game_over), 1);
    check("tie_win", 32'(winner), 0);

    // P2 sweeps the board
    do_start();
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) pulse(1'b1, 1'b0);
    check("p2win_p2", 32'(p2_score), 8);
    check("p2win_over", 32'(game_over), 1);
    check("p2win_win", 32'(winner), 2);

    // 6. reset mid-game with P1=2, timer 07
    do_start();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    tick(32);
    check_timer("mid", 4'd0, 4'd7);
    check("mid_p1", 32'(p1_score), 2);
    #2 reset = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("post_rst_tick", 32'(sec_tick), 0);
    end
    check_timer("post_rst", 4'd1, 4'd5);
    do_start();
    tick(4);
    check("restart_tick", 32'(sec_tick), 1);
    check_timer("restart", 4'd1, 4'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
